// File: rtl/chan_scan_if.sv
// Channel scan sequencer control/status bundle.
// master drives the control side, slave is the sequencer.
interface chan_scan_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               continuous;
  logic [15:0]        chan_mask;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         sel;
  logic               sel_valid;
  logic               chan_tick;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, continuous,
    output chan_mask, dwell,
    input  sel, sel_valid, chan_tick,
    input  busy, done
  );

  modport slave (
    input  start, stop, continuous,
    input  chan_mask, dwell,
    output sel, sel_valid, chan_tick,
    output busy, done
  );
endinterface

// File: rtl/chan_scan_sequencer.sv
// Ascending channel scanner driving a 4-to-16 decoder select,
// with per-channel dwell, single-pass or wrap-around modes.
module chan_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input logic      clk,
  input logic      rst_n,
  chan_scan_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    DWELL,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        mask_q, mask_d;
  logic [DWELL_W-1:0] dw_q, dw_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               cont_q, cont_d;
  logic [3:0]         ptr_q, ptr_d;
  logic               end_q, end_d;
  logic [3:0]         sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               hit;
  logic [3:0]         hit_idx;
  logic [3:0]         low_idx;

  // Lowest enabled channel at/above ptr, and lowest overall for wrap.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 4'd0;
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_q[i]) begin
        low_idx = 4'(i);
        if (4'(i) >= ptr_q) begin
          hit     = 1'b1;
          hit_idx = 4'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      dw_q    <= '0;
      cnt_q   <= '0;
      cont_q  <= 1'b0;
      ptr_q   <= '0;
      end_q   <= 1'b0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dw_q    <= dw_d;
      cnt_q   <= cnt_d;
      cont_q  <= cont_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dw_d    = dw_q;
    cnt_d   = cnt_q;
    cont_d  = cont_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    sel_d   = sel_q;
    if (bus.stop && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            mask_d  = bus.chan_mask;
            dw_d    = bus.dwell;
            cont_d  = bus.continuous;
            ptr_d   = 4'd0;
            end_d   = 1'b0;
            state_d = (|bus.chan_mask) ? SEEK : DONE;
          end
        end
        SEEK: begin
          if (hit && !end_q) begin
            sel_d   = hit_idx;
            cnt_d   = '0;
            state_d = DWELL;
          end else if (cont_q) begin
            sel_d   = low_idx;
            cnt_d   = '0;
            state_d = DWELL;
          end else begin
            state_d = DONE;
          end
        end
        DWELL: begin
          if (cnt_q == dw_q) begin
            ptr_d   = sel_q + 4'd1;
            // ptr wraps past 15; the flag remembers the pass is over.
            end_d   = (sel_q == 4'd15) && !cont_q;
            state_d = SEEK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    valid_d = (state_d == DWELL);
    tick_d  = (state_d == DWELL) && (state_q == SEEK);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = valid_q;
  assign bus.chan_tick = tick_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_chan_scan_sequencer.sv
// Bench for chan_scan_sequencer: table runs, reset, random scans
// compared cycle by cycle against a trace built from scan rules.
module tb_chan_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chan_scan_if #(.DWELL_W(8)) bus ();

  chan_scan_sequencer #(.DWELL_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] sel;
    logic       v;
    logic       tick;
    logic       busy;
    logic       done;
  } out_t;

  typedef struct {
    logic [15:0] mask;
    logic [7:0]  dwell;
    bit          cont;
    int          stop_at;
    int          cap;
    int          exp_ticks;
    bit          exp_done;
  } vec_t;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] cur_sel = 4'd0;
  out_t       exp_q[$];
  vec_t       tbl[6];

  function automatic out_t mk(input logic [3:0] s, input logic v,
                              input logic t, input logic b,
                              input logic d);
    out_t o;
    o.sel = s; o.v = v; o.tick = t; o.busy = b; o.done = d;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input out_t e, input string nm);
    n_vec++;
    if (bus.sel !== e.sel || bus.sel_valid !== e.v ||
        bus.chan_tick !== e.tick || bus.busy !== e.busy ||
        bus.done !== e.done) begin
      n_bad++;
      $display("FAIL %s: got sel=%0d v=%b tick=%b busy=%b done=%b want sel=%0d v=%b tick=%b busy=%b done=%b",
               nm, bus.sel, bus.sel_valid, bus.chan_tick, bus.busy,
               bus.done, e.sel, e.v, e.tick, e.busy, e.done);
    end
  endtask

  task automatic chk_int(input int got, input int want, input string nm);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Expected per-cycle outputs after the start edge: each visited
  // channel is one idle-select cycle plus dwell+1 held cycles.
  task automatic build(input logic [15:0] m, input logic [7:0] dw,
                       input bit c, input int cap);
    logic [3:0] s;
    s = cur_sel;
    exp_q.delete();
    if (m == 16'h0) begin
      exp_q.push_back(mk(s, 0, 0, 1, 1));
      return;
    end
    forever begin
      for (int ch = 0; ch < 16; ch++) begin
        if (m[ch]) begin
          exp_q.push_back(mk(s, 0, 0, 1, 0));
          s = 4'(ch);
          for (int d = 0; d <= int'(dw); d++)
            exp_q.push_back(mk(s, 1, d == 0, 1, 0));
          if (exp_q.size() >= cap) return;
        end
      end
      if (!c) begin
        exp_q.push_back(mk(s, 0, 0, 1, 0));
        exp_q.push_back(mk(s, 0, 0, 1, 1));
        return;
      end
    end
  endtask

  task automatic run_scan(input logic [15:0] m, input logic [7:0] dw,
                          input bit c, input int stop_in,
                          input int cap, input string nm,
                          output int ticks, output bit saw_done);
    int stop_at;
    stop_at = stop_in;
    bus.start      = 1'b1;
    bus.chan_mask  = m;
    bus.dwell      = dw;
    bus.continuous = c;
    bus.stop       = 1'($urandom_range(0, 1));
    build(m, dw, c, cap);
    if (c && (stop_at < 0 || stop_at >= exp_q.size()))
      stop_at = exp_q.size() - 1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    ticks     = 0;
    saw_done  = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      chk(exp_q[k], nm);
      cur_sel = exp_q[k].sel;
      ticks += int'(bus.chan_tick);
      if (bus.done === 1'b1) saw_done = 1'b1;
      // Scramble inputs mid-scan; none of it may matter.
      bus.chan_mask  = 16'($urandom);
      bus.dwell      = 8'($urandom);
      bus.continuous = 1'($urandom);
      bus.start      = ($urandom_range(0, 3) == 0);
      if (k == stop_at) begin
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        break;
      end
      step();
    end
    bus.start = 1'b0;
    chk(mk(cur_sel, 0, 0, 0, 0), {nm, "_idle"});
  endtask

  initial begin
    int   ticks;
    bit   sd;
    int   r;
    logic [15:0] m;
    bit   c;
    int   sa;

    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.continuous = 1'b0;
    bus.chan_mask  = '0;
    bus.dwell      = '0;

    tbl[0] = '{16'h8421, 8'd2,   1'b0, -1, 100000, 4, 1'b1};
    tbl[1] = '{16'h0000, 8'd3,   1'b0, -1, 100000, 0, 1'b1};
    tbl[2] = '{16'h0003, 8'd0,   1'b1,  7, 40,     4, 1'b0};
    tbl[3] = '{16'h8000, 8'hFF,  1'b0, -1, 100000, 1, 1'b1};
    tbl[4] = '{16'h0001, 8'd0,   1'b1, 10, 40,     5, 1'b0};
    tbl[5] = '{16'h0003, 8'd1,   1'b0, -1, 100000, 2, 1'b1};

    step();
    chk(mk(0, 0, 0, 0, 0), "reset");
    rst_n = 1'b1;
    step();
    chk(mk(0, 0, 0, 0, 0), "post_reset");

    // Asynchronous reset in the middle of channel 5's dwell.
    bus.start     = 1'b1;
    bus.chan_mask = 16'h0020;
    bus.dwell     = 8'd10;
    step();
    bus.start = 1'b0;
    chk(mk(0, 0, 0, 1, 0), "rst_seek");
    step();
    chk(mk(5, 1, 1, 1, 0), "rst_dwell");
    step();
    chk(mk(5, 1, 0, 1, 0), "rst_dwell2");
    #2 rst_n = 1'b0;
    #1 chk(mk(0, 0, 0, 0, 0), "rst_async");
    step();
    rst_n = 1'b1;
    step();
    chk(mk(0, 0, 0, 0, 0), "rst_release");
    step();
    chk(mk(0, 0, 0, 0, 0), "rst_no_done");
    cur_sel = 4'd0;

    for (int i = 0; i < 6; i++) begin
      run_scan(tbl[i].mask, tbl[i].dwell, tbl[i].cont,
               tbl[i].stop_at, tbl[i].cap, $sformatf("tbl%0d", i),
               ticks, sd);
      chk_int(ticks, tbl[i].exp_ticks, $sformatf("tbl%0d_ticks", i));
      chk_int(int'(sd), int'(tbl[i].exp_done),
              $sformatf("tbl%0d_done", i));
    end

    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 3);
      unique case (r)
        0: m = 16'($urandom);
        1: m = 16'h1 << $urandom_range(0, 15);
        2: m = 16'h0;
        default: m = 16'($urandom) & 16'($urandom);
      endcase
      c  = 1'($urandom_range(0, 1));
      sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1;
      run_scan(m, 8'($urandom_range(0, 4)), c, sa, c ? 50 : 100000,
               $sformatf("rnd%0d", i), ticks, sd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
